// File: rtl/pipeline_debug_ctrl.sv
// Run/step/halt sequencer for the 5-stage pipeline with a byte-serial state dump:
// pc, cycle count, then registers 0..REG_COUNT-1, each MSByte first.
module pipeline_debug_ctrl #(
  parameter int          REG_COUNT = 32,
  parameter logic [7:0]  CMD_RUN   = 8'h63,
  parameter logic [7:0]  CMD_STEP  = 8'h73,
  parameter logic [7:0]  CMD_DUMP  = 8'h64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_code,
  output logic        cmd_ready,
  input  logic        halt_detected,
  input  logic [31:0] pc_in,
  output logic [4:0]  addrAsync,
  input  logic [31:0] outputAsync,
  output logic        stall,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] cycle_count
);

  typedef enum logic [2:0] {
    IDLE, RUN, STEP, LOAD_PC, LOAD_REG, WAIT_REG, SEND
  } state_t;

  localparam logic [6:0] LP_REGS = 7'(REG_COUNT);

  state_t      r_state, w_next;
  logic [63:0] r_shift;
  logic [3:0]  r_cnt;
  logic [5:0]  r_idx;
  logic [4:0]  r_addr;
  logic [31:0] r_cycle;

  logic w_accept;
  logic w_last_byte;
  logic w_more_regs;
  logic w_adv;

  assign w_accept    = (r_state == IDLE) && cmd_valid;
  assign w_last_byte = (r_state == SEND) && tx_ready && (r_cnt == 4'd1);
  assign w_more_regs = ({1'b0, r_idx} < LP_REGS);

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if      (cmd_code == CMD_RUN)  w_next = RUN;
          else if (cmd_code == CMD_STEP) w_next = STEP;
          else if (cmd_code == CMD_DUMP) w_next = LOAD_PC;
        end
      end
      RUN:      if (halt_detected) w_next = LOAD_PC;
      STEP:     w_next = LOAD_PC;
      LOAD_PC:  w_next = SEND;
      SEND:     if (w_last_byte) w_next = w_more_regs ? LOAD_REG : IDLE;
      LOAD_REG: w_next = WAIT_REG;
      WAIT_REG: w_next = SEND;
      default:  w_next = IDLE;
    endcase
  end

  // Pipeline only advances in RUN/STEP; everything else freezes it.
  always_comb begin
    w_adv     = (r_state == RUN) || (r_state == STEP);
    stall     = !w_adv;
    cmd_ready = (r_state == IDLE) && !reset;
    tx_valid  = (r_state == SEND);
    tx_data   = (r_state == SEND) ? r_shift[63:56] : 8'h00;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_addr  <= '0;
      r_cycle <= '0;
    end else begin
      if (w_adv) r_cycle <= r_cycle + 32'd1;
      case (r_state)
        LOAD_PC: begin
          r_shift <= {pc_in, r_cycle};
          r_cnt   <= 4'd8;
          r_idx   <= '0;
        end
        SEND: begin
          if (tx_ready) begin
            r_shift <= {r_shift[55:0], 8'h00};
            r_cnt   <= r_cnt - 4'd1;
          end
        end
        LOAD_REG: r_addr <= r_idx[4:0];
        // Read data settles during WAIT_REG; capture it into the top word.
        WAIT_REG: begin
          r_shift[63:32] <= outputAsync;
          r_cnt          <= 4'd4;
          r_idx          <= r_idx + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign addrAsync   = r_addr;
  assign cycle_count = r_cycle;

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Directed bench for pipeline_debug_ctrl: run/step/dump commands, byte stream and reset abort.
module tb_pipeline_debug_ctrl;
  logic        clock = 0;
  logic        reset = 1;
  logic        cmd_valid = 0;
  logic [7:0]  cmd_code = 0;
  logic        cmd_ready;
  logic        halt_detected = 0;
  logic [31:0] pc_in = 32'h0040_1234;
  logic [4:0]  addrAsync;
  logic [31:0] outputAsync;
  logic        stall;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 0;
  logic [31:0] cycle_count;

  logic [31:0] regs [32];
  logic [7:0]  rx [256];
  int n_chk = 0, n_pass = 0;
  int run_clks = 0;
  int viol = 0;

  pipeline_debug_ctrl dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_ready(cmd_ready), .halt_detected(halt_detected), .pc_in(pc_in),
    .addrAsync(addrAsync), .outputAsync(outputAsync), .stall(stall),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;
  assign outputAsync = regs[addrAsync];

  always @(negedge clock) if (!reset && !stall) run_clks++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] exp_byte(input int k, input logic [31:0] pc, input logic [31:0] cyc);
    logic [31:0] w;
    int b;
    if (k < 4)      begin w = pc;  b = k; end
    else if (k < 8) begin w = cyc; b = k - 4; end
    else            begin w = regs[(k - 8) / 4]; b = (k - 8) % 4; end
    return w[31 - 8*b -: 8];
  endfunction

  task automatic chk_stream(input string tag, input int n, input logic [31:0] cyc);
    int bad = 0;
    for (int k = 0; k < 136; k++) if (rx[k] !== exp_byte(k, pc_in, cyc)) bad++;
    chk({tag, "_len"}, 64'(n), 64'd136);
    chk({tag, "_bytes_bad"}, 64'(bad), 64'd0);
  endtask

  task automatic send_cmd(input logic [7:0] c, output logic rdy);
    cmd_valid = 1; cmd_code = c;
    rdy = cmd_ready;
    @(negedge clock);
    cmd_valid = 0;
  endtask

  // mode 0: tx_ready always 1; mode 1: toggles. max_bytes>0 stops early.
  task automatic collect(input int mode, input int max_bytes, output int n);
    logic pv = 0, pr = 0, done = 0;
    logic [7:0] pd = 0;
    n = 0;
    for (int c = 0; c < 4000 && !done; c++) begin
      tx_ready = (mode == 0) ? 1'b1 : (c % 2 == 0);
      if (pv && !pr && (!tx_valid || tx_data !== pd)) viol++;
      if (n > 0 && cmd_ready) done = 1;
      else begin
        if (tx_valid && tx_ready) begin rx[n] = tx_data; n++; end
        pv = tx_valid; pr = tx_ready; pd = tx_data;
        @(negedge clock);
        if (max_bytes > 0 && n == max_bytes) done = 1;
      end
    end
    tx_ready = 0;
    if (!done) chk("collect_timeout", 64'd1, 64'd0);
  endtask

  task automatic do_reset();
    reset = 1; cmd_valid = 0; halt_detected = 0; tx_ready = 0;
    repeat (2) @(negedge clock);
    reset = 0;
  endtask

  initial begin
    logic rdy;
    int n, base, bad_s, bad_v, bad_c;
    for (int i = 0; i < 32; i++) regs[i] = (32'h0101_0101 * i) ^ 32'hA500_0000;
    regs[5] = 32'hDEAD_BEEF;

    // T1: reset values and idle hold
    repeat (2) @(negedge clock);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_addr", addrAsync, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_stall", stall, 1);
    chk("rst_cycle", cycle_count, 0);
    reset = 0;
    bad_s = 0; bad_v = 0; bad_c = 0;
    repeat (100) begin
      @(negedge clock);
      if (stall !== 1) bad_s++;
      if (tx_valid !== 0) bad_v++;
      if (cycle_count !== 0) bad_c++;
    end
    chk("idle_stall_bad", 64'(bad_s), 0);
    chk("idle_txv_bad", 64'(bad_v), 0);
    chk("idle_cycle_bad", 64'(bad_c), 0);
    chk("idle_cmd_ready", cmd_ready, 1);

    // T2: run, halt 10 clocks later
    base = run_clks;
    send_cmd(8'h63, rdy);
    chk("run_accept", rdy, 1);
    repeat (10) @(negedge clock);
    chk("run_stall_low", stall, 0);
    halt_detected = 1;
    @(negedge clock);
    halt_detected = 0;
    chk("halt_stall", stall, 1);
    chk("halt_cycle", cycle_count, 11);
    chk("run_clks", 64'(run_clks - base), 11);
    collect(0, 0, n);
    chk_stream("run_dump", n, 32'd11);
    chk("run_pc_b0", rx[0], 8'h00);
    chk("run_pc_b1", rx[1], 8'h40);
    chk("run_pc_b2", rx[2], 8'h12);
    chk("run_pc_b3", rx[3], 8'h34);
    chk("run_cyc_b7", rx[7], 8'h0B);

    // T6: reset after 50 dump bytes
    send_cmd(8'h64, rdy);
    collect(0, 50, n);
    chk("partial_len", 64'(n), 50);
    reset = 1;
    @(negedge clock);
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_stall", stall, 1);
    chk("abort_cycle", cycle_count, 0);
    reset = 0;
    @(negedge clock);
    send_cmd(8'h64, rdy);
    chk("redump_accept", rdy, 1);
    collect(0, 0, n);
    chk_stream("redump", n, 32'd0);

    // T3: two single steps from reset
    do_reset();
    base = run_clks;
    send_cmd(8'h73, rdy);
    collect(0, 0, n);
    chk("step1_clks", 64'(run_clks - base), 1);
    chk_stream("step1", n, 32'd1);
    send_cmd(8'h73, rdy);
    collect(0, 0, n);
    chk("step2_clks", 64'(run_clks - base), 2);
    chk_stream("step2", n, 32'd2);
    chk("step2_b4_7", {rx[4], rx[5], rx[6], rx[7]}, 32'h0000_0002);

    // T4: dump with toggling tx_ready
    do_reset();
    viol = 0;
    send_cmd(8'h64, rdy);
    collect(1, 0, n);
    chk_stream("toggle", n, 32'd0);
    chk("toggle_r5", {rx[28], rx[29], rx[30], rx[31]}, 32'hDEAD_BEEF);
    chk("toggle_hold_viol", 64'(viol), 0);
    chk("toggle_run_none", cycle_count, 0);

    // T5: unknown command consumed; command during dump refused
    send_cmd(8'h41, rdy);
    chk("unk_accept", rdy, 1);
    bad_v = 0;
    repeat (5) begin
      if (tx_valid !== 0 || stall !== 1 || cmd_ready !== 1) bad_v++;
      @(negedge clock);
    end
    chk("unk_idle_bad", 64'(bad_v), 0);
    send_cmd(8'h64, rdy);
    repeat (3) @(negedge clock);
    chk("dump_tx_valid", tx_valid, 1);
    cmd_valid = 1; cmd_code = 8'h63;
    chk("dump_cmd_ready", cmd_ready, 0);
    @(negedge clock);
    chk("dump_cmd_stall", stall, 1);
    cmd_valid = 0;
    collect(0, 0, n);
    chk_stream("busy_dump", n, 32'd0);
    chk("busy_no_run", cycle_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
